aes_enc_core: RTL and testbench
===============================

# aes_enc_core

Parametrised iterative AES encryption core, the successor to the fixed AES-128 datapath/controlpath pair. It supports 128- or 256-bit keys (elaboration-time), ECB or CBC chaining (run-time), and valid/ready handshakes on input and output. Round keys are expanded on the fly, one round per clock. It sits between the block-stream source and the ciphertext sink, and replaces the free-running top in new integrations.

## Interface
- KEY_BITS, 128, key length; legal values 128 or 256; sets Nr = 10 or 14.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low.
- key  in  KEY_BITS  cipher key; used only when key_load = 1.
- key_load  in  1  latch key; honoured only in IDLE.
- iv  in  128  CBC initial vector.
- iv_load  in  1  latch iv into the chain register; honoured only in IDLE.
- cbc  in  1  mode select, 1 = CBC, 0 = ECB; sampled at input handshake.
- in_data  in  128  plaintext block.
- in_valid  in  1  plaintext valid.
- in_ready  out  1  core can accept a block.
- out_data  out  128  ciphertext.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  sink accepts ciphertext.
- busy  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, ROUND, OUT.
- in_ready = (state == IDLE). busy = !in_ready.
- key_load and iv_load in IDLE:
  - Register key → key_reg and iv → chain_reg.
  - If either is asserted in the same cycle as an accepted block, the new key/IV applies to that block (bypass mux).
  - Both are ignored in ROUND and OUT.
- Accept (in_valid & in_ready):
  - st ← in_data ^ (cbc ? chain : 0) ^ rk0.
  - Round counter ← 1; mode latched; state → ROUND.
- ROUND, round r:
  - r < Nr: st ← MixColumns(ShiftRows(SubBytes(st))) ^ rk_r.
  - r = Nr: MixColumns is omitted, result goes to out_data, state → OUT.
- Key schedule runs on the fly:
  - Working key register, 128 or 256 bits, produces rk_r in cycle r.
  - AES-256: odd-indexed expansions use SubWord without RotWord/Rcon, per FIPS-197.
  - key_reg itself is never modified; the next block restarts from it.
- OUT:
  - out_valid = 1 and out_data held stable until out_ready.
  - On handshake: if latched mode is CBC, chain ← out_data. State → IDLE.
- ECB never modifies chain_reg.
- Reset values: state IDLE, in_ready 1, busy 0, out_valid 0, out_data 0, key_reg 0, chain_reg 0, st 0, counter 0.

## Timing
- Accept edge T0; rounds at edges T1..TNr; out_valid is high from TNr.
- Latency is 10 cycles (AES-128) or 14 cycles (AES-256) from accept to out_valid.
- Backpressure:
  - out_valid stays high and out_data stays constant for any number of cycles with out_ready = 0.
  - in_ready stays 0 during this time.
- in_ready returns high in the cycle after the output handshake. Peak throughput is one block per Nr + 2 cycles.
- in_valid while busy: no effect; the source must hold the block until in_ready.
- rst asserted mid-operation:
  - Immediate, clock-independent return to reset values; the in-flight block is discarded.
  - Key and IV are lost and must be reloaded.
- Counter width: 4 bits; no wrap within legal Nr.

## Structure
- Package aes_pkg holds:
  - state enum;
  - Rcon table (10 entries);
  - function nr_of(KEY_BITS);
  - functions xtime, mix_columns, shift_rows.
- Sub-module aes_sbox: combinational byte S-box.
  - 16 instances for the state.
  - 4 instances for the key schedule SubWord.
- The top-level FSM, datapath and key schedule live in aes_enc_core.
- An elaboration-time check rejects KEY_BITS other than 128 or 256.

## Test plan
- AES-128 ECB, FIPS-197:
  - key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → 69c4e0d86a7b0430d8cdb78070b4c55a.
  - out_valid exactly 10 cycles after accept.
- AES-256 ECB (KEY_BITS = 256):
  - key 000102…1e1f, same pt → 8ea2b7ca516745bfeafc49904b496089.
  - Latency 14.
- AES-128 CBC, SP800-38A:
  - key 2b7e151628aed2a6abf7158809cf4f3c, iv 000102…0f.
  - Block 6bc1bee22e409f96e93d7e117393172a → 7649abac8119b246cee98e9b12e9197d.
  - Next block ae2d8a571e03ac9c9eb76fac45af8e51 → 5086cb9b507219ee95db113a917678b2.
- ECB with the same key, pt 6bc1bee22e409f96e93d7e117393172a → 3ad77bb40d7a3660a89ecaf32466ef97. Issue it twice; both outputs are identical.
- Backpressure and ignored loads:
  - Hold out_ready = 0 for 20 cycles; out_data is stable and in_ready = 0 throughout.
  - key_load pulsed during ROUND is ignored, so the next block's ciphertext is unchanged.
- Reset mid-round:
  - Assert rst at round 5. Outputs go to reset values without a clock edge.
  - After reload, FIPS-197 vector 1 passes again.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types, constants and round-function helpers
// for the iterative AES encryption core.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    OUT
  } state_e;

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [3:0] nr_of(int kb);
    return (kb == 256) ? 4'd14 : 4'd10;
  endfunction

  function automatic logic [7:0] rcon_at(logic [3:0] i);
    return (i < 4'd10) ? RCON[i] : 8'h00;
  endfunction

  function automatic logic [7:0] xtime(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte 0 is the MSB; byte 4c+r is row r of column c
  function automatic logic [127:0] shift_rows(logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] =
          s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_enc_core_if.sv
// Block-stream, key/IV load and ciphertext handshake
// bundle for aes_enc_core.
interface aes_enc_core_if #(
  parameter int KEY_BITS = 128
);

  logic [KEY_BITS-1:0] key;
  logic                key_load;
  logic [127:0]        iv;
  logic                iv_load;
  logic                cbc;
  logic [127:0]        in_data;
  logic                in_valid;
  logic                in_ready;
  logic [127:0]        out_data;
  logic                out_valid;
  logic                out_ready;
  logic                busy;

  modport master (
    output key, key_load, iv, iv_load, cbc,
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, busy
  );

  modport slave (
    input  key, key_load, iv, iv_load, cbc,
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, busy
  );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES S-box: GF(2^8) inverse as x^254
// followed by the affine transform.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_b,
  output logic [7:0] out_b
);

  function automatic logic [7:0] gmul(
    logic [7:0] a,
    logic [7:0] b
  );
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x12, x15;
  logic [7:0] x30, x60, x120, x240, x252, inv;

  always_comb begin
    x2   = gmul(in_b, in_b);
    x3   = gmul(x2, in_b);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    x252 = gmul(x240, x12);
    inv  = gmul(x252, x2);
    out_b = inv
          ^ {inv[6:0], inv[7]}
          ^ {inv[5:0], inv[7:6]}
          ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]}
          ^ 8'h63;
  end

endmodule

// File: rtl/aes_enc_core.sv
// Iterative AES-128/256 encryptor, one round per clock,
// on-the-fly key expansion, ECB/CBC, valid/ready I/O.
module aes_enc_core
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input logic           clk,
  input logic           rst,
  aes_enc_core_if.slave io
);

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key
    $error("aes_enc_core: KEY_BITS must be 128 or 256");
  end

  localparam logic [3:0] NR = nr_of(KEY_BITS);

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic mode_q, mode_d;
  logic [KEY_BITS-1:0] key_q, key_d;
  logic [KEY_BITS-1:0] work_q, work_d;
  logic [127:0] chain_q, chain_d;
  logic [127:0] st_q, st_d;
  logic [127:0] out_q, out_d;

  logic [KEY_BITS-1:0] key_eff, work_nx;
  logic [127:0] chain_eff, rk0, rk;
  logic [127:0] sb, sr, mc;
  logic [127:0] exp_prev, exp_new;
  logic [31:0] sw_in, sw_out, tmp;
  logic rot;
  logic [7:0] rc;

  assign key_eff   = io.key_load ? io.key : key_q;
  assign chain_eff = io.iv_load ? io.iv : chain_q;

  for (genvar i = 0; i < 16; i++) begin : g_sb
    aes_sbox u_sb (
      .in_b  (st_q[8*i +: 8]),
      .out_b (sb[8*i +: 8])
    );
  end

  for (genvar i = 0; i < 4; i++) begin : g_ks
    aes_sbox u_ks (
      .in_b  (sw_in[8*i +: 8]),
      .out_b (sw_out[8*i +: 8])
    );
  end

  assign sr = shift_rows(sb);
  assign mc = mix_columns(sr);

  // AES-128: work holds rk_{r-1} and rk_r is derived
  // from it; AES-256: work holds {rk_{r-1}, rk_r}.
  if (KEY_BITS == 256) begin : g_k256
    assign sw_in    = work_q[31:0];
    assign exp_prev = work_q[255:128];
    assign rot      = cnt_q[0];
    assign rc       = rcon_at((cnt_q - 4'd1) >> 1);
    assign rk       = work_q[127:0];
    assign work_nx  = {work_q[127:0], exp_new};
    assign rk0      = key_eff[255:128];
  end else begin : g_k128
    assign sw_in    = work_q[31:0];
    assign exp_prev = work_q;
    assign rot      = 1'b1;
    assign rc       = rcon_at(cnt_q - 4'd1);
    assign rk       = exp_new;
    assign work_nx  = exp_new;
    assign rk0      = key_eff;
  end

  always_comb begin
    tmp = rot ? ({sw_out[23:0], sw_out[31:24]} ^ {rc, 24'h0})
              : sw_out;
    exp_new[127:96] = exp_prev[127:96] ^ tmp;
    exp_new[95:64]  = exp_prev[95:64]  ^ exp_new[127:96];
    exp_new[63:32]  = exp_prev[63:32]  ^ exp_new[95:64];
    exp_new[31:0]   = exp_prev[31:0]   ^ exp_new[63:32];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    key_d   = key_q;
    work_d  = work_q;
    chain_d = chain_q;
    st_d    = st_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        key_d   = key_eff;
        chain_d = chain_eff;
        if (io.in_valid) begin
          st_d = io.in_data ^ rk0
               ^ (io.cbc ? chain_eff : 128'h0);
          work_d  = key_eff;
          cnt_d   = 4'd1;
          mode_d  = io.cbc;
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (cnt_q == NR) begin
          out_d   = sr ^ rk;
          cnt_d   = '0;
          state_d = OUT;
        end else begin
          st_d   = mc ^ rk;
          work_d = work_nx;
          cnt_d  = cnt_q + 4'd1;
        end
      end
      OUT: begin
        if (io.out_ready) begin
          if (mode_q) chain_d = out_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      key_q   <= '0;
      work_q  <= '0;
      chain_q <= '0;
      st_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      key_q   <= key_d;
      work_q  <= work_d;
      chain_q <= chain_d;
      st_q    <= st_d;
      out_q   <= out_d;
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.busy      = (state_q != IDLE);
  assign io.out_valid = (state_q == OUT);
  assign io.out_data  = out_q;

endmodule

// File: tb/tb_aes_enc_core.sv
// Directed-vector bench for aes_enc_core, AES-128 and
// AES-256 instances side by side.
module tb_aes_enc_core;

  localparam logic [127:0] KA  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K2  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] CF1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CF2 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CE1 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] CC1 = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] CC2 = 128'h5086cb9b507219ee95db113a917678b2;

  logic clk, rst;
  logic sel;
  int checks, errors;

  aes_enc_core_if #(.KEY_BITS(128)) if128 ();
  aes_enc_core_if #(.KEY_BITS(256)) if256 ();

  aes_enc_core #(.KEY_BITS(128)) u128 (
    .clk (clk), .rst (rst), .io (if128)
  );
  aes_enc_core #(.KEY_BITS(256)) u256 (
    .clk (clk), .rst (rst), .io (if256)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic m_ready, m_valid, m_busy;
  logic [127:0] m_data;
  assign m_ready = sel ? if256.in_ready  : if128.in_ready;
  assign m_valid = sel ? if256.out_valid : if128.out_valid;
  assign m_busy  = sel ? if256.busy      : if128.busy;
  assign m_data  = sel ? if256.out_data  : if128.out_data;

  typedef struct {
    logic         s;
    logic [255:0] k;
    logic         kl;
    logic [127:0] iv;
    logic         il;
    logic         c;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t v [7];

  task automatic chk(input string nm,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic start_blk(input logic s,
                           input logic [255:0] k,
                           input logic kl,
                           input logic [127:0] ivv,
                           input logic il,
                           input logic c,
                           input logic [127:0] pt);
    @(negedge clk);
    sel = s;
    #1;
    chk("in_ready_idle", 256'(m_ready), 256'(1'b1));
    if (s) begin
      if256.key = k; if256.key_load = kl;
      if256.iv = ivv; if256.iv_load = il;
      if256.cbc = c; if256.in_data = pt;
      if256.in_valid = 1'b1;
    end else begin
      if128.key = k[127:0]; if128.key_load = kl;
      if128.iv = ivv; if128.iv_load = il;
      if128.cbc = c; if128.in_data = pt;
      if128.in_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    if256.in_valid = 1'b0; if256.key_load = 1'b0;
    if256.iv_load = 1'b0;
    if128.in_valid = 1'b0; if128.key_load = 1'b0;
    if128.iv_load = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      lat++;
      #1;
      if (m_valid) break;
    end
    if (!m_valid) begin
      errors++;
      $display("FAIL out_valid_timeout got 0 want 1");
    end
  endtask

  task automatic take_out(output logic [127:0] ct);
    ct = m_data;
    if (sel) if256.out_ready = 1'b1;
    else     if128.out_ready = 1'b1;
    @(posedge clk);
    #1;
    if256.out_ready = 1'b0;
    if128.out_ready = 1'b0;
    chk("in_ready_after_hs", 256'(m_ready), 256'(1'b1));
  endtask

  task automatic run_vec(input vec_t t, input string nm);
    int lat;
    logic [127:0] ct;
    start_blk(t.s, t.k, t.kl, t.iv, t.il, t.c, t.pt);
    wait_out(lat);
    chk({nm, "_lat"}, 256'(lat), t.s ? 256'(14) : 256'(10));
    take_out(ct);
    chk({nm, "_ct"}, 256'(ct), 256'(t.ct));
  endtask

  initial begin
    int lat;
    logic [127:0] ct;
    checks = 0;
    errors = 0;
    sel = 1'b0;
    if128.key = '0; if128.key_load = 1'b0;
    if128.iv = '0; if128.iv_load = 1'b0;
    if128.cbc = 1'b0; if128.in_data = '0;
    if128.in_valid = 1'b0; if128.out_ready = 1'b0;
    if256.key = '0; if256.key_load = 1'b0;
    if256.iv = '0; if256.iv_load = 1'b0;
    if256.cbc = 1'b0; if256.in_data = '0;
    if256.in_valid = 1'b0; if256.out_ready = 1'b0;

    v[0] = '{1'b0, {128'h0, KA}, 1'b1, 128'h0, 1'b0, 1'b0, PT0, CF1};
    v[1] = '{1'b1, K2, 1'b1, 128'h0, 1'b0, 1'b0, PT0, CF2};
    v[2] = '{1'b0, {128'h0, KB}, 1'b1, 128'h0, 1'b0, 1'b0, P1, CE1};
    v[3] = '{1'b0, {256{1'b1}}, 1'b0, 128'h0, 1'b0, 1'b0, P1, CE1};
    v[4] = '{1'b0, {256{1'b1}}, 1'b0, IV, 1'b1, 1'b1, P1, CC1};
    v[5] = '{1'b0, {256{1'b1}}, 1'b0, 128'h0, 1'b0, 1'b1, P2, CC2};
    v[6] = '{1'b0, {256{1'b1}}, 1'b0, 128'h0, 1'b0, 1'b0, P1, CE1};

    rst = 1'b0;
    #3;
    chk("rst_in_ready", 256'(if128.in_ready), 256'(1'b1));
    chk("rst_busy", 256'(if128.busy), 256'(1'b0));
    chk("rst_out_valid", 256'(if128.out_valid), 256'(1'b0));
    chk("rst_out_data", 256'(if128.out_data), 256'(0));
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_vec(v[i], $sformatf("vec%0d", i));
    end

    // Backpressure with ignored key/IV loads and a stray
    // in_valid while busy.
    start_blk(1'b0, {256{1'b1}}, 1'b0, 128'h0, 1'b0, 1'b0, P1);
    if128.key = '1; if128.key_load = 1'b1;
    if128.iv = '1; if128.iv_load = 1'b1;
    if128.in_data = P2; if128.in_valid = 1'b1;
    wait_out(lat);
    chk("bp_lat", 256'(lat), 256'(10));
    if128.key_load = 1'b0; if128.iv_load = 1'b0;
    if128.in_valid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("bp_hold", {126'h0, m_data, m_ready, m_valid},
          {126'h0, CE1, 1'b0, 1'b1});
    end
    take_out(ct);
    chk("bp_ct", 256'(ct), 256'(CE1));
    run_vec(v[6], "after_ignored_load");

    // Reset in the middle of round 5
    start_blk(1'b0, {128'h0, KA}, 1'b1, 128'h0, 1'b0, 1'b0, PT0);
    repeat (4) @(posedge clk);
    #3;
    chk("pre_rst_busy", 256'(if128.busy), 256'(1'b1));
    rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", 256'(if128.in_ready), 256'(1'b1));
    chk("mid_rst_busy", 256'(if128.busy), 256'(1'b0));
    chk("mid_rst_out_valid", 256'(if128.out_valid), 256'(1'b0));
    chk("mid_rst_out_data", 256'(if128.out_data), 256'(0));
    @(negedge clk);
    rst = 1'b1;
    run_vec(v[0], "post_rst_fips");
    // chain register was cleared, so CBC equals ECB here
    run_vec('{1'b0, {128'h0, KB}, 1'b1, 128'h0, 1'b0, 1'b1, P1, CE1},
            "post_rst_cbc_zero_chain");
    run_vec(v[1], "post_rst_256");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
